// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard controller.
//   state_e : controller FSM states (RUN, STALL, FLUSH)
//   FWD_*   : execute-stage operand forwarding select encodings
// ---------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Operand source select for the execute-stage operand muxes
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file read value
  localparam logic [1:0] FWD_MEM = 2'b01;  // memory-stage result
  localparam logic [1:0] FWD_WB  = 2'b10;  // writeback-stage result

endpackage : hazard_pkg

// File: rtl/fwd_unit.sv
// ---------------------------------------------------------------------------
// fwd_unit
// Forwarding select for one execute-stage operand. A producer only counts
// when it writes a register, lives in the same register file (scalar vs
// vector) and targets the same index. The memory stage is younger than
// writeback, so it wins when both match. Register 0 is not special.
//
// Ports:
//   src_i       in  REG_W  execute-stage source index
//   vf_i        in  1      execute-stage vector-file flag
//   mem_dest_i  in  REG_W  memory-stage destination
//   mem_wreg_i  in  1      memory stage writes a register
//   mem_vf_i    in  1      memory-stage vector-file flag
//   wb_dest_i   in  REG_W  writeback-stage destination
//   wb_wreg_i   in  1      writeback stage writes a register
//   wb_vf_i     in  1      writeback-stage vector-file flag
//   sel_o       out 2      operand select (FWD_RF / FWD_MEM / FWD_WB)
// ---------------------------------------------------------------------------
module fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0] src_i,
  input  logic             vf_i,
  input  logic [REG_W-1:0] mem_dest_i,
  input  logic             mem_wreg_i,
  input  logic             mem_vf_i,
  input  logic [REG_W-1:0] wb_dest_i,
  input  logic             wb_wreg_i,
  input  logic             wb_vf_i,
  output logic [1:0]       sel_o
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_wreg_i & (mem_vf_i == vf_i) & (mem_dest_i == src_i);
  assign wb_hit  = wb_wreg_i  & (wb_vf_i  == vf_i) & (wb_dest_i  == src_i);

  always_comb begin
    sel_o = FWD_RF;
    if (mem_hit) begin
      sel_o = FWD_MEM;
    end else if (wb_hit) begin
      sel_o = FWD_WB;
    end
  end

endmodule : fwd_unit

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the 5-stage vector ASIP. Produces load-use
// stalls, taken-jump flushes and the execute-stage forwarding selects.
//
// Optional feature (macro HAZARD_PERF_EN): adds saturating 32-bit counters
// stall_cnt (cycles with stall_pc=1) and flush_cnt (cycles with flush_id=1).
//
// Ports:
//   clk        in  1      system clock
//   rst        in  1      asynchronous active-low reset
//   id_src_a   in  REG_W  decode first source index
//   id_src_b   in  REG_W  decode second source index
//   id_vf      in  1      decode uses vector file
//   ex_src_a   in  REG_W  execute first source index
//   ex_src_b   in  REG_W  execute second source index
//   ex_vf      in  1      execute vector flag
//   ex_dest    in  REG_W  execute destination
//   ex_wreg    in  1      execute writes register
//   ex_rmem    in  1      execute is a load
//   mem_dest   in  REG_W  memory destination
//   mem_wreg   in  1      memory writes register
//   mem_vf     in  1      memory vector flag
//   wb_dest    in  REG_W  writeback destination
//   wb_wreg    in  1      writeback writes register
//   wb_vf      in  1      writeback vector flag
//   jmp_taken  in  1      execute resolved a taken jump
//   stall_pc   out 1      hold PC
//   stall_id   out 1      hold fetch/decode register
//   bubble_ex  out 1      load NOP into decode/execute register
//   flush_id   out 1      clear fetch/decode register
//   fwd_a      out 2      operand A select (00 RF, 01 MEM, 10 WB)
//   fwd_b      out 2      operand B select
//   busy       out 1      state != RUN (registered)
//   stall_cnt  out 32     [HAZARD_PERF_EN] stall cycle count
//   flush_cnt  out 32     [HAZARD_PERF_EN] flush cycle count
// ---------------------------------------------------------------------------
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL   = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int REG_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_src_a,
  input  logic [REG_W-1:0] id_src_b,
  input  logic             id_vf,
  input  logic [REG_W-1:0] ex_src_a,
  input  logic [REG_W-1:0] ex_src_b,
  input  logic             ex_vf,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_wreg,
  input  logic             ex_rmem,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wreg,
  input  logic             mem_vf,
  input  logic [REG_W-1:0] wb_dest,
  input  logic             wb_wreg,
  input  logic             wb_vf,
  input  logic             jmp_taken,
`ifdef HAZARD_PERF_EN
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt,
`endif
  output logic             stall_pc,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             busy
);

  localparam int MAX_CYC = (LOAD_STALL > FLUSH_CYCLES) ? LOAD_STALL : FLUSH_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC + 1) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic       luh;
  logic       stall_c;
  logic       flush_c;
  logic [1:0] fwd_a_c;
  logic [1:0] fwd_b_c;

  // Load in execute whose destination is read by the instruction in decode,
  // same register file only.
  assign luh = ex_rmem & ex_wreg & (ex_vf == id_vf) &
               ((ex_dest == id_src_a) | (ex_dest == id_src_b));

  // -------------------------------------------------------------------------
  // FSM state and counter register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and raw control outputs. A taken jump overrides everything,
  // including a stall in progress, so the jump target is never held off.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    flush_c = 1'b0;

    if (jmp_taken) begin
      flush_c = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
      end else begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (luh) begin
            stall_c = 1'b1;
            if (LOAD_STALL > 1) begin
              state_d = STALL;
              cnt_d   = CNT_W'(LOAD_STALL - 1);
            end
          end
        end
        STALL: begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
          // A hazard still present here is picked up again from RUN next cycle
          if (cnt_q == CNT_W'(1)) begin
            state_d = RUN;
          end
        end
        FLUSH: begin
          flush_c = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Forwarding selects, one unit per execute operand
  // -------------------------------------------------------------------------
  fwd_unit #(.REG_W(REG_W)) u_fwd_a (
    .src_i      (ex_src_a),
    .vf_i       (ex_vf),
    .mem_dest_i (mem_dest),
    .mem_wreg_i (mem_wreg),
    .mem_vf_i   (mem_vf),
    .wb_dest_i  (wb_dest),
    .wb_wreg_i  (wb_wreg),
    .wb_vf_i    (wb_vf),
    .sel_o      (fwd_a_c)
  );

  fwd_unit #(.REG_W(REG_W)) u_fwd_b (
    .src_i      (ex_src_b),
    .vf_i       (ex_vf),
    .mem_dest_i (mem_dest),
    .mem_wreg_i (mem_wreg),
    .mem_vf_i   (mem_vf),
    .wb_dest_i  (wb_dest),
    .wb_wreg_i  (wb_wreg),
    .wb_vf_i    (wb_vf),
    .sel_o      (fwd_b_c)
  );

  // Combinational outputs are forced low while reset is asserted so the
  // pipeline sees a quiet controller even if inputs are toggling.
  assign stall_pc  = rst & stall_c;
  assign stall_id  = rst & stall_c;
  assign bubble_ex = rst & (stall_c | flush_c);
  assign flush_id  = rst & flush_c;
  assign fwd_a     = rst ? fwd_a_c : FWD_RF;
  assign fwd_b     = rst ? fwd_b_c : FWD_RF;
  assign busy      = (state_q != RUN);

`ifdef HAZARD_PERF_EN
  // -------------------------------------------------------------------------
  // Saturating performance counters
  // -------------------------------------------------------------------------
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_pc && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (flush_id && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule : hazard_ctrl
